// File: rtl/scan_chain_controller.sv
// Scan chain sequencer: optional capture pulse, then a CHAIN_LEN-bit MSB-first shift that
// loads the host word into the chain and returns the unloaded word. All outputs registered.
module scan_chain_controller #(
  parameter int unsigned CHAIN_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 capture,
  input  logic [CHAIN_LEN-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rd_data,
  output logic                 chain_enable,
  output logic                 chain_scan_en,
  output logic                 chain_scan_in,
  input  logic                 chain_scan_out
);

  localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {StIdle, StCapture, StShift, StDone} state_e;

  state_e               state_q, state_d;
  logic [CHAIN_LEN-1:0] tx_q, tx_d;
  logic [CHAIN_LEN-1:0] rx_q, rx_d;
  logic [CHAIN_LEN-1:0] rd_data_q, rd_data_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 busy_q, done_q, enable_q, scan_en_q, scan_in_q;
  logic                 busy_d, done_d, enable_d, scan_en_d, scan_in_d;

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          tx_d    = wr_data;
          cnt_d   = '0;
          state_d = capture ? StCapture : StShift;
        end
      end
      StCapture: state_d = StShift;
      StShift: begin
        tx_d  = tx_q << 1;
        rx_d  = (rx_q << 1) | CHAIN_LEN'(chain_scan_out);
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d   = StDone;
          // Final bit arrives on this edge, so publish the assembled word directly.
          rd_data_d = rx_d;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
    enable_d  = (state_d == StCapture);
    scan_en_d = (state_d == StShift);
    scan_in_d = (state_d == StShift) & tx_d[CHAIN_LEN-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      enable_q  <= 1'b0;
      scan_en_q <= 1'b0;
      scan_in_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      enable_q  <= enable_d;
      scan_en_q <= scan_en_d;
      scan_in_q <= scan_in_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rd_data       = rd_data_q;
  assign chain_enable  = enable_q;
  assign chain_scan_en = scan_en_q;
  assign chain_scan_in = scan_in_q;

endmodule

// File: tb/tb_scan_chain_controller.sv
// Directed bench for scan_chain_controller with behavioural scan chains for CHAIN_LEN=8 and 1.
module tb_scan_chain_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, capture;
  logic [7:0] wr_data, rd_data;
  logic       busy, done, ch_en, scan_en, scan_in, scan_out;

  logic       start1, capture1;
  logic [0:0] wr1, rd1;
  logic       busy1, done1, en1, scan_en1, scan_in1, scan_out1;

  logic [7:0] chain_q  = 8'h00;
  logic [7:0] data_in  = 8'h00;
  logic       chain1_q = 1'b0;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  scan_chain_controller #(.CHAIN_LEN(8)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .capture        (capture),
    .wr_data        (wr_data),
    .busy           (busy),
    .done           (done),
    .rd_data        (rd_data),
    .chain_enable   (ch_en),
    .chain_scan_en  (scan_en),
    .chain_scan_in  (scan_in),
    .chain_scan_out (scan_out)
  );

  scan_chain_controller #(.CHAIN_LEN(1)) u_dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start1),
    .capture        (capture1),
    .wr_data        (wr1),
    .busy           (busy1),
    .done           (done1),
    .rd_data        (rd1),
    .chain_enable   (en1),
    .chain_scan_en  (scan_en1),
    .chain_scan_in  (scan_in1),
    .chain_scan_out (scan_out1)
  );

  // Scan chains: scan_enable shifts towards the MSB, enable loads data_in.
  always @(posedge clk) begin
    if (scan_en) chain_q <= {chain_q[6:0], scan_in};
    else if (ch_en) chain_q <= data_in;
    if (scan_en1) chain1_q <= scan_in1;
    else if (en1) chain1_q <= 1'b0;
  end
  assign scan_out  = chain_q[7];
  assign scan_out1 = chain1_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one command and follows it to its done cycle (cycle 1 = first after accept edge).
  task automatic run_cmd(input logic [7:0] wr, input logic cap, output int done_cyc,
                         output int en_cnt, output int en_first, output int sh_cnt,
                         output logic [7:0] bits, output logic [7:0] rd);
    done_cyc = 0; en_cnt = 0; en_first = 0; sh_cnt = 0; bits = 8'h00; rd = 8'h00;
    start = 1'b1; capture = cap; wr_data = wr;
    tick();
    start = 1'b0; capture = 1'b0; wr_data = 8'h00;
    for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
      if (scan_en) begin
        bits = {bits[6:0], scan_in};
        sh_cnt++;
      end
      if (ch_en) begin
        en_cnt++;
        if (en_first == 0) en_first = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        rd = rd_data;
      end else begin
        tick();
      end
    end
  endtask

  int         dc, ec, ef, sc, ndone, nfound;
  int         done_at[2];
  logic [7:0] bits, rd, rd_seen[2];

  initial begin
    rst_n = 1'b0; start = 1'b0; capture = 1'b0; wr_data = 8'h00;
    start1 = 1'b0; capture1 = 1'b0; wr1 = 1'b0;
    tick(); tick();
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_rd", 32'(rd_data), 32'h0);
    check_eq("rst_chain_outs", 32'({ch_en, scan_en, scan_in}), 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: plain shift of 0xA5 into an all-zero chain
    run_cmd(8'hA5, 1'b0, dc, ec, ef, sc, bits, rd);
    check_eq("t1_done_cyc", 32'(dc), 32'd9);
    check_eq("t1_shift_cnt", 32'(sc), 32'd8);
    check_eq("t1_serial", 32'(bits), 32'hA5);
    check_eq("t1_no_enable", 32'(ec), 32'd0);
    check_eq("t1_rd", 32'(rd), 32'h00);
    check_eq("t1_chain", 32'(chain_q), 32'hA5);
    check_eq("t1_busy_at_done", 32'(busy), 32'h1);
    tick();
    check_eq("t1_done_pulse", 32'({busy, done}), 32'h0);

    // 2: back-to-back word returns the previous one
    run_cmd(8'h3C, 1'b0, dc, ec, ef, sc, bits, rd);
    check_eq("t2_done_cyc", 32'(dc), 32'd9);
    check_eq("t2_rd", 32'(rd), 32'hA5);
    check_eq("t2_chain", 32'(chain_q), 32'h3C);
    tick();

    // 3: capture first, then shift
    data_in = 8'h5A;
    run_cmd(8'hFF, 1'b1, dc, ec, ef, sc, bits, rd);
    check_eq("t3_en_cnt", 32'(ec), 32'd1);
    check_eq("t3_en_cyc", 32'(ef), 32'd1);
    check_eq("t3_done_cyc", 32'(dc), 32'd10);
    check_eq("t3_shift_cnt", 32'(sc), 32'd8);
    check_eq("t3_rd", 32'(rd), 32'h5A);
    check_eq("t3_chain", 32'(chain_q), 32'hFF);
    tick();

    // 4: start held high through two full commands plus a third acceptance
    start = 1'b1; wr_data = 8'h81;
    tick();
    ndone = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (done) begin
        if (ndone < 2) begin
          done_at[ndone] = cyc;
          rd_seen[ndone] = rd_data;
        end
        ndone++;
      end
      if (cyc == 10) check_eq("t4_idle_gap", 32'(busy), 32'h0);
      if (cyc == 11) check_eq("t4_reaccept", 32'(busy), 32'h1);
      tick();
    end
    start = 1'b0; wr_data = 8'h00;
    check_eq("t4_ndone", 32'(ndone), 32'd2);
    check_eq("t4_done0", 32'(done_at[0]), 32'd9);
    check_eq("t4_done1", 32'(done_at[1]), 32'd19);
    check_eq("t4_rd0", 32'(rd_seen[0]), 32'hFF);
    check_eq("t4_rd1", 32'(rd_seen[1]), 32'h81);
    nfound = 0;
    for (int i = 0; i < 15 && nfound == 0; i++) begin
      if (done) nfound = 1;
      else tick();
    end
    check_eq("t4_third_done", 32'(nfound), 32'd1);
    check_eq("t4_chain", 32'(chain_q), 32'h81);
    tick();

    // 5: reset in the fourth shift cycle aborts with partial chain contents
    start = 1'b1; wr_data = 8'h0F;
    tick();
    start = 1'b0; wr_data = 8'h00;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check_eq("t5_busy", 32'(busy), 32'h0);
    check_eq("t5_done", 32'(done), 32'h0);
    check_eq("t5_chain_outs", 32'({ch_en, scan_en, scan_in}), 32'h0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    check_eq("t5_no_done", 32'(ndone), 32'd0);
    check_eq("t5_partial_chain", 32'(chain_q), 32'h10);
    run_cmd(8'h66, 1'b0, dc, ec, ef, sc, bits, rd);
    check_eq("t5_next_done_cyc", 32'(dc), 32'd9);
    check_eq("t5_next_rd", 32'(rd), 32'h10);
    check_eq("t5_next_chain", 32'(chain_q), 32'h66);
    tick();

    // 6: single-bit chain
    for (int k = 0; k < 2; k++) begin
      start1 = 1'b1; wr1 = (k == 0) ? 1'b1 : 1'b0;
      tick();
      start1 = 1'b0; wr1 = 1'b0;
      dc = 0; sc = 0; rd = 8'h00;
      for (int cyc = 1; cyc <= 6 && dc == 0; cyc++) begin
        if (scan_en1) sc++;
        if (done1) begin
          dc = cyc;
          rd = {7'b0, rd1};
        end else begin
          tick();
        end
      end
      check_eq("t6_done_cyc", 32'(dc), 32'd2);
      check_eq("t6_shift_cnt", 32'(sc), 32'd1);
      check_eq("t6_rd", 32'(rd), (k == 0) ? 32'h0 : 32'h1);
      check_eq("t6_chain", 32'(chain1_q), (k == 0) ? 32'h1 : 32'h0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
